// File: rtl/countdown_timer_bank_pkg.sv
// Shared types and defaults for the countdown timer bank.
package timer_pkg;
    localparam int TIMER_DEFAULT_WIDTH  = 16;
    localparam int TIMER_DEFAULT_NUM_CH = 4;
    localparam int TIMER_DEFAULT_CH_W   = $clog2(TIMER_DEFAULT_NUM_CH);

    typedef logic [TIMER_DEFAULT_CH_W-1:0]  ch_idx_t;
    typedef logic [TIMER_DEFAULT_WIDTH-1:0] tcount_t;
endpackage

// File: rtl/countdown_timer_bank_if.sv
// Method bundle of the timer bank: start, abort, busy and expiry-event handshakes.
interface countdown_timer_bank_if
    import timer_pkg::*;
#(
    parameter int NUM_CH = TIMER_DEFAULT_NUM_CH,
    parameter int WIDTH  = TIMER_DEFAULT_WIDTH
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              start__ENA;
    logic [CH_W-1:0]   start_ch;
    logic [WIDTH-1:0]  start_count;
    logic              start_periodic;
    logic              start__RDY;
    logic              abort__ENA;
    logic [CH_W-1:0]   abort_ch;
    logic              abort__RDY;
    logic [NUM_CH-1:0] busy;
    logic              busy__RDY;
    logic              expire__ENA;
    logic              expire__RDY;
    logic [CH_W-1:0]   expire_ch;
    logic              expire_overrun;

    modport master (
        output start__ENA, start_ch, start_count, start_periodic,
        output abort__ENA, abort_ch, expire__ENA,
        input  start__RDY, abort__RDY, busy, busy__RDY,
        input  expire__RDY, expire_ch, expire_overrun
    );

    modport slave (
        input  start__ENA, start_ch, start_count, start_periodic,
        input  abort__ENA, abort_ch, expire__ENA,
        output start__RDY, abort__RDY, busy, busy__RDY,
        output expire__RDY, expire_ch, expire_overrun
    );
endinterface

// File: rtl/countdown_timer_bank_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping; one-hot grant plus index.
module rr_pick #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx
);
    always_comb begin
        int   w_j;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_CH;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = CH_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/countdown_timer_bank.sv
// NUM_CH independent countdown timers with one-shot/periodic reload and a
// round-robin expiry-event queue that flags events lost while one was pending.
module countdown_timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_CH = TIMER_DEFAULT_NUM_CH,
    parameter int WIDTH  = TIMER_DEFAULT_WIDTH
) (
    input logic                  CLK,
    input logic                  RST,
    countdown_timer_bank_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [WIDTH-1:0]  r_cnt  [NUM_CH];
    logic [WIDTH-1:0]  r_load [NUM_CH];
    logic [NUM_CH-1:0] r_per, r_busy, r_pend, r_ovr;
    logic [CH_W-1:0]   r_rr_ptr;

    logic [NUM_CH-1:0] w_start_hit, w_abort_hit, w_raise, w_take, w_grant;
    logic [CH_W-1:0]   w_pick_ch;
    logic              w_accept;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .i_req   (r_pend),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_pick_ch)
    );

    assign w_accept = bus.expire__ENA && (|r_pend);

    // Abort beats start beats decrement; a start or abort landing on the
    // expiring cycle swallows that expiry, while a zero-length start expires at once.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_start_hit[g] = bus.start__ENA && (bus.start_ch == CH_W'(g));
        assign w_abort_hit[g] = bus.abort__ENA && (bus.abort_ch == CH_W'(g));
        assign w_raise[g]     = w_abort_hit[g] ? 1'b0 :
                                w_start_hit[g] ? (bus.start_count == '0) :
                                (r_busy[g] && (r_cnt[g] == WIDTH'(1)));
        assign w_take[g]      = w_accept && w_grant[g];
`ifdef FORMAL
        always @(posedge CLK) begin
            if (!RST) begin
                assert (!r_busy[g] || (r_cnt[g] >= WIDTH'(1) && r_cnt[g] <= r_load[g]));
                assert (r_busy[g] || r_cnt[g] == '0);
                assert (!r_ovr[g] || r_pend[g]);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]  <= '0;
                r_load[i] <= '0;
            end
            r_per    <= '0;
            r_busy   <= '0;
            r_pend   <= '0;
            r_ovr    <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_abort_hit[i]) begin
                    r_busy[i] <= 1'b0;
                    r_per[i]  <= 1'b0;
                    r_cnt[i]  <= '0;
                end else if (w_start_hit[i]) begin
                    if (bus.start_count != '0) begin
                        r_cnt[i]  <= bus.start_count;
                        r_load[i] <= bus.start_count;
                        r_per[i]  <= bus.start_periodic;
                        r_busy[i] <= 1'b1;
                    end else begin
                        r_cnt[i]  <= '0;
                        r_busy[i] <= 1'b0;
                    end
                end else if (r_busy[i] && r_cnt[i] != '0) begin
                    if (r_cnt[i] == WIDTH'(1)) begin
                        if (r_per[i]) begin
                            r_cnt[i] <= r_load[i];
                        end else begin
                            r_cnt[i]  <= '0;
                            r_busy[i] <= 1'b0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] - WIDTH'(1);
                    end
                end
                // A fresh expiry re-arms pending even if it is being consumed;
                // overrun only marks expiries that land on an unconsumed event.
                r_pend[i] <= w_raise[i] | (r_pend[i] & ~w_take[i]);
                r_ovr[i]  <= ~w_take[i] & (r_ovr[i] | (w_raise[i] & r_pend[i]));
            end
            if (w_accept)
                r_rr_ptr <= (w_pick_ch == CH_W'(NUM_CH - 1)) ? '0 : w_pick_ch + CH_W'(1);
        end
    end

    assign bus.start__RDY     = 1'b1;
    assign bus.abort__RDY     = 1'b1;
    assign bus.busy__RDY      = 1'b1;
    assign bus.busy           = r_busy;
    assign bus.expire__RDY    = |r_pend;
    assign bus.expire_ch      = w_pick_ch;
    assign bus.expire_overrun = r_ovr[w_pick_ch];
endmodule
